// File: rtl/max1119x_conv_scheduler.sv
// Round-robin conversion scheduler for a MAX1119x ADC: arbitrates requesters, holds CS high
// for conversion, shifts in one 16-bit frame and presents it on an AXI-Stream master.
module max1119x_conv_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int SCLK_DIV    = 10,
  parameter int CS_HIGH_CYC = 600,
  parameter int NBITS       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         chan_sel,
  output logic               cs_n,
  output logic               sclk,
  input  logic               miso,
  output logic [NBITS-1:0]   m_axis_tdata,
  output logic [1:0]         m_axis_tuser,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               busy
);

  localparam int CONV_W = $clog2(CS_HIGH_CYC + 1);
  localparam int DIV_W  = $clog2(SCLK_DIV + 1);
  localparam int HALF_W = $clog2(2 * NBITS);
  localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(CS_HIGH_CYC - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * NBITS - 1);

  typedef enum logic [1:0] {IDLE, CONV, SHIFT, HOLD} state_t;

  state_t              state, state_n;
  logic [NUM_REQ-1:0]  grant_n;
  logic [1:0]          chan_n, ptr, ptr_n, pick;
  logic                cs_n_n, sclk_n, found, load, can_load;
  logic [CONV_W-1:0]   conv_cnt, conv_cnt_n;
  logic [DIV_W-1:0]    div_cnt, div_cnt_n;
  logic [HALF_W-1:0]   half_cnt, half_cnt_n;
  logic [NBITS-1:0]    shreg, shreg_n, tdata_n;
  logic [1:0]          tuser_n;
  logic                tvalid_n;
  logic [2:0]          cand, nxt;

  assign busy     = (state != IDLE);
  assign can_load = !m_axis_tvalid || m_axis_tready;

  // Round-robin pick: first set request at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    cand  = 3'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + 3'(i);
      if (cand >= 3'(NUM_REQ)) cand = cand - 3'(NUM_REQ);
      if (!found && req[cand[1:0]]) begin
        found = 1'b1;
        pick  = cand[1:0];
      end
    end
  end

  always_comb begin
    state_n    = state;
    grant_n    = grant;
    chan_n     = chan_sel;
    cs_n_n     = cs_n;
    sclk_n     = sclk;
    conv_cnt_n = conv_cnt;
    div_cnt_n  = div_cnt;
    half_cnt_n = half_cnt;
    shreg_n    = shreg;
    tdata_n    = m_axis_tdata;
    tuser_n    = m_axis_tuser;
    tvalid_n   = m_axis_tvalid;
    ptr_n      = ptr;
    load       = 1'b0;
    nxt        = {1'b0, pick} + 3'd1;
    if (nxt >= 3'(NUM_REQ)) nxt = 3'd0;
    if (m_axis_tvalid && m_axis_tready) tvalid_n = 1'b0;

    case (state)
      IDLE: begin
        if (found) begin
          grant_n       = '0;
          grant_n[pick] = 1'b1;
          chan_n        = pick;
          ptr_n         = nxt[1:0];
          conv_cnt_n    = '0;
          state_n       = CONV;
        end
      end
      CONV: begin
        if (conv_cnt == CONV_LAST) begin
          cs_n_n     = 1'b0;
          sclk_n     = 1'b0;
          div_cnt_n  = '0;
          half_cnt_n = '0;
          shreg_n    = '0;
          state_n    = SHIFT;
        end else begin
          conv_cnt_n = conv_cnt + CONV_W'(1);
        end
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_n = '0;
          if (half_cnt == HALF_LAST) begin
            sclk_n  = 1'b0;
            cs_n_n  = 1'b1;
            load    = can_load;
            state_n = can_load ? IDLE : HOLD;
          end else begin
            // Data is captured on the edge that raises sclk.
            sclk_n     = ~sclk;
            half_cnt_n = half_cnt + HALF_W'(1);
            if (!sclk) shreg_n = {shreg[NBITS-2:0], miso};
          end
        end else begin
          div_cnt_n = div_cnt + DIV_W'(1);
        end
      end
      HOLD: begin
        if (can_load) begin
          load    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (load) begin
      tdata_n  = shreg;
      tuser_n  = chan_sel;
      tvalid_n = 1'b1;
      grant_n  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      grant         <= '0;
      chan_sel      <= 2'd0;
      cs_n          <= 1'b1;
      sclk          <= 1'b0;
      conv_cnt      <= '0;
      div_cnt       <= '0;
      half_cnt      <= '0;
      shreg         <= '0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 2'd0;
      m_axis_tvalid <= 1'b0;
      ptr           <= 2'd0;
    end else begin
      state         <= state_n;
      grant         <= grant_n;
      chan_sel      <= chan_n;
      cs_n          <= cs_n_n;
      sclk          <= sclk_n;
      conv_cnt      <= conv_cnt_n;
      div_cnt       <= div_cnt_n;
      half_cnt      <= half_cnt_n;
      shreg         <= shreg_n;
      m_axis_tdata  <= tdata_n;
      m_axis_tuser  <= tuser_n;
      m_axis_tvalid <= tvalid_n;
      ptr           <= ptr_n;
    end
  end

endmodule

// File: tb/tb_max1119x_conv_scheduler.sv
// Bench for max1119x_conv_scheduler: ADC serial models plus a round-robin/timing reference
// derived from the scheduling rules, checked with immediate assertions.
module tb_max1119x_conv_scheduler;

  localparam int D     = 2;
  localparam int C     = 5;
  localparam int FRAME = C + 32 * D;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0, grant;
  logic [1:0]  chan_sel, tuser;
  logic        cs_n, sclk, miso = 1'b0, tvalid, tready = 1'b0, busy;
  logic [15:0] tdata;

  logic [3:0]  req_f = '0, grant_f;
  logic [1:0]  chan_sel_f, tuser_f;
  logic        cs_n_f, sclk_f, miso_f = 1'b0, tvalid_f, tready_f = 1'b0, busy_f;
  logic [15:0] tdata_f;

  int total = 0, bad = 0, cyc = 0;
  int model_ptr = 0, exp_idx, last_g, nrise, cs_fall, cs_rise, errs, n;
  int rises[16];
  logic        prev_sclk, prev_cs, snap_valid;
  logic [15:0] snap_data, w0, w1, fixed_word = '0;
  logic [1:0]  snap_user;
  logic [3:0]  snap_grant;
  logic        use_fixed = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] fast_q[$];

  always #5 clk = ~clk;

  max1119x_conv_scheduler #(.NUM_REQ(4), .SCLK_DIV(D), .CS_HIGH_CYC(C), .NBITS(16)) dut (
    .clk(clk), .reset(reset), .req(req), .grant(grant), .chan_sel(chan_sel),
    .cs_n(cs_n), .sclk(sclk), .miso(miso), .m_axis_tdata(tdata), .m_axis_tuser(tuser),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .busy(busy));

  max1119x_conv_scheduler #(.NUM_REQ(4), .SCLK_DIV(1), .CS_HIGH_CYC(1), .NBITS(16)) dut_f (
    .clk(clk), .reset(reset), .req(req_f), .grant(grant_f), .chan_sel(chan_sel_f),
    .cs_n(cs_n_f), .sclk(sclk_f), .miso(miso_f), .m_axis_tdata(tdata_f), .m_axis_tuser(tuser_f),
    .m_axis_tvalid(tvalid_f), .m_axis_tready(tready_f), .busy(busy_f));

  // ADC model: new word at each CS fall, MSB first, next bit after each sclk fall.
  initial begin
    logic [15:0] word;
    int bit_i;
    forever begin
      @(negedge cs_n);
      word = use_fixed ? fixed_word : 16'($urandom);
      exp_q.push_back(word);
      bit_i = 15;
      miso = word[15];
      while (bit_i > 0) begin
        @(negedge sclk or posedge cs_n);
        if (cs_n) break;
        bit_i--;
        miso = word[bit_i];
      end
    end
  end

  initial begin
    logic [15:0] word;
    int bit_i;
    forever begin
      @(negedge cs_n_f);
      word = 16'($urandom);
      fast_q.push_back(word);
      bit_i = 15;
      miso_f = word[15];
      while (bit_i > 0) begin
        @(negedge sclk_f or posedge cs_n_f);
        if (cs_n_f) break;
        bit_i--;
        miso_f = word[bit_i];
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int rr_pick(input logic [3:0] r, input int start);
    for (int i = 0; i < 4; i++)
      if (r[(start + i) % 4]) return (start + i) % 4;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus_reset();
    reset = 1'b1;
    req = '0;
    req_f = '0;
    tready = 1'b0;
    tready_f = 1'b0;
    step();
    step();
    reset = 1'b0;
    exp_q.delete();
    fast_q.delete();
    model_ptr = 0;
  endtask

  task automatic wait_grant(input string tag);
    int k = 0;
    while (grant === 4'b0000 && k < 300) begin step(); k++; end
    check_output({tag, "_grant_seen"}, 32'(grant !== 4'b0000), 1);
  endtask

  task automatic wait_tvalid(input string tag);
    int k = 0;
    while (tvalid !== 1'b1 && k < 300) begin step(); k++; end
    check_output({tag, "_tvalid_seen"}, 32'(tvalid === 1'b1), 1);
  endtask

  task automatic expect_grant(input string tag);
    exp_idx = rr_pick(req, model_ptr);
    model_ptr = (exp_idx + 1) % 4;
    check_output({tag, "_grant"}, 32'(grant), 32'(4'b0001 << exp_idx));
    check_output({tag, "_chan_sel"}, 32'(chan_sel), 32'(exp_idx));
  endtask

  task automatic pop_word(output logic [15:0] w, input string tag);
    check_output({tag, "_q_nonempty"}, 32'(exp_q.size() > 0), 1);
    w = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
  endtask

  initial begin
    // Reset values
    step();
    step();
    check_output("rst_grant", 32'(grant), 0);
    check_output("rst_chan_sel", 32'(chan_sel), 0);
    check_output("rst_cs_n", 32'(cs_n), 1);
    check_output("rst_sclk", 32'(sclk), 0);
    check_output("rst_tdata", 32'(tdata), 0);
    check_output("rst_tuser", 32'(tuser), 0);
    check_output("rst_tvalid", 32'(tvalid), 0);
    check_output("rst_busy", 32'(busy), 0);
    apply_stimulus_reset();

    // Single requester, fixed word, frame timing
    $display("[TB] single requester timing");
    use_fixed = 1'b1;
    fixed_word = 16'hA5C3;
    req = 4'b0100;
    step();
    expect_grant("t1");
    check_output("t1_busy", 32'(busy), 1);
    req = '0;
    cs_fall = -1; cs_rise = -1; nrise = 0; prev_sclk = sclk; prev_cs = cs_n;
    for (int t = 1; t <= FRAME + 2; t++) begin
      step();
      if (prev_cs && !cs_n && cs_fall < 0) cs_fall = t;
      if (!prev_cs && cs_n && cs_rise < 0) begin
        cs_rise = t;
        snap_valid = tvalid; snap_data = tdata; snap_user = tuser; snap_grant = grant;
      end
      if (!prev_sclk && sclk) begin
        if (nrise < 16) rises[nrise] = t;
        nrise++;
      end
      prev_sclk = sclk;
      prev_cs = cs_n;
    end
    check_output("t1_cs_fall", cs_fall, C);
    check_output("t1_cs_rise", cs_rise, FRAME);
    check_output("t1_nrise", nrise, 16);
    for (int k = 0; k < 16; k++)
      check_output($sformatf("t1_rise%0d", k), rises[k], C + D + 2 * k * D);
    check_output("t1_tvalid", 32'(snap_valid), 1);
    check_output("t1_tdata", 32'(snap_data), 32'h0000A5C3);
    check_output("t1_tuser", 32'(snap_user), 2);
    check_output("t1_grant_clear", 32'(snap_grant), 0);
    tready = 1'b1;
    step();
    check_output("t1_accept", 32'(tvalid), 0);

    // All requesters, random words, round-robin order and throughput
    $display("[TB] round robin");
    apply_stimulus_reset();
    use_fixed = 1'b0;
    tready = 1'b1;
    req = 4'b1111;
    errs = 0;
    last_g = 0;
    for (int f = 0; f < 5; f++) begin
      wait_grant("rr");
      if (f > 0) check_output("rr_period", cyc - last_g, FRAME + 1);
      last_g = cyc;
      expect_grant("rr");
      n = 0;
      while (tvalid !== 1'b1 && n < 300) begin
        step();
        n++;
        if ($countones(grant) > 1) errs++;
      end
      pop_word(w0, "rr");
      check_output("rr_tdata", 32'(tdata), 32'(w0));
      check_output("rr_tuser", 32'(tuser), exp_idx);
    end
    check_output("rr_onehot", errs, 0);
    req = '0;

    // Backpressure: second frame parks in HOLD until the first word is taken
    $display("[TB] backpressure");
    apply_stimulus_reset();
    req = 4'b0011;
    wait_grant("bp1");
    expect_grant("bp1");
    wait_tvalid("bp1");
    pop_word(w0, "bp1");
    check_output("bp1_tdata", 32'(tdata), 32'(w0));
    check_output("bp1_tuser", 32'(tuser), 0);
    wait_grant("bp2");
    expect_grant("bp2");
    req = '0;
    errs = 0;
    for (int t = 1; t <= FRAME + 3; t++) begin
      step();
      if (tvalid !== 1'b1 || tdata !== w0 || tuser !== 2'd0) errs++;
    end
    check_output("bp_stable", errs, 0);
    check_output("bp_hold_cs_n", 32'(cs_n), 1);
    check_output("bp_hold_sclk", 32'(sclk), 0);
    check_output("bp_hold_grant", 32'(grant), 32'(4'b0010));
    check_output("bp_hold_busy", 32'(busy), 1);
    tready = 1'b1;
    step();
    pop_word(w1, "bp2");
    check_output("bp2_tvalid", 32'(tvalid), 1);
    check_output("bp2_tdata", 32'(tdata), 32'(w1));
    check_output("bp2_tuser", 32'(tuser), 1);
    check_output("bp2_grant", 32'(grant), 0);
    step();
    check_output("bp2_drain", 32'(tvalid), 0);

    // Reset in the middle of a frame
    $display("[TB] reset mid-frame");
    apply_stimulus_reset();
    req = 4'b0001;
    wait_grant("mr1");
    expect_grant("mr1");
    req = '0;
    wait_tvalid("mr1");
    pop_word(w0, "mr1");
    check_output("mr1_tdata", 32'(tdata), 32'(w0));
    req = 4'b0001;
    wait_grant("mr2");
    expect_grant("mr2");
    req = '0;
    nrise = 0;
    n = 0;
    prev_sclk = sclk;
    while (nrise < 7 && n < 300) begin
      step();
      n++;
      if (!prev_sclk && sclk) nrise++;
      prev_sclk = sclk;
    end
    check_output("mr_seven_rises", nrise, 7);
    reset = 1'b1;
    step();
    check_output("mr_cs_n", 32'(cs_n), 1);
    check_output("mr_sclk", 32'(sclk), 0);
    check_output("mr_grant", 32'(grant), 0);
    check_output("mr_tvalid", 32'(tvalid), 0);
    check_output("mr_tdata", 32'(tdata), 0);
    check_output("mr_busy", 32'(busy), 0);
    reset = 1'b0;
    model_ptr = 0;
    exp_q.delete();
    req = 4'b0011;
    step();
    expect_grant("mr3");
    req = '0;
    wait_tvalid("mr3");
    pop_word(w1, "mr3");
    check_output("mr3_tdata", 32'(tdata), 32'(w1));
    check_output("mr3_tuser", 32'(tuser), 0);
    check_output("mr3_q_empty", exp_q.size(), 0);

    // Constant miso levels
    $display("[TB] constant miso");
    apply_stimulus_reset();
    tready = 1'b1;
    use_fixed = 1'b1;
    fixed_word = 16'hFFFF;
    req = 4'b0001;
    wait_grant("m1");
    req = '0;
    wait_tvalid("m1");
    check_output("m1_tdata", 32'(tdata), 32'h0000FFFF);
    fixed_word = 16'h0000;
    step();
    req = 4'b0001;
    wait_grant("m0");
    req = '0;
    wait_tvalid("m0");
    check_output("m0_tdata", 32'(tdata), 0);
    use_fixed = 1'b0;

    // Fastest timing on the second instance
    $display("[TB] fast instance");
    apply_stimulus_reset();
    tready_f = 1'b1;
    req_f = 4'b1000;
    step();
    check_output("f_grant", 32'(grant_f), 32'(4'b1000));
    req_f = '0;
    cs_fall = -1; cs_rise = -1; errs = 0; prev_cs = cs_n_f;
    for (int t = 1; t <= 36; t++) begin
      step();
      if (prev_cs && !cs_n_f && cs_fall < 0) cs_fall = t;
      if (!prev_cs && cs_n_f && cs_rise < 0) begin
        cs_rise = t;
        snap_valid = tvalid_f; snap_data = tdata_f; snap_user = tuser_f;
      end
      if (cs_fall >= 0 && cs_rise < 0 && t > cs_fall)
        if (sclk_f !== 1'(((t - cs_fall) % 2) == 1)) errs++;
      prev_cs = cs_n_f;
    end
    check_output("f_cs_fall", cs_fall, 1);
    check_output("f_cs_rise", cs_rise, 33);
    check_output("f_sclk_toggle", errs, 0);
    check_output("f_q_nonempty", 32'(fast_q.size() > 0), 1);
    w0 = (fast_q.size() > 0) ? fast_q.pop_front() : 16'hxxxx;
    check_output("f_tvalid", 32'(snap_valid), 1);
    check_output("f_tdata", 32'(snap_data), 32'(w0));
    check_output("f_tuser", 32'(snap_user), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/max1119x_conv_scheduler.md
Name: max1119x_conv_scheduler

Overview:
- Sequences MAX1119x ADC conversions and shares the single ADC SPI read path among NUM_REQ requesters using round-robin arbitration.
- For each granted request: drives the analog mux select, holds the conversion window (CS high), clocks out one 16-bit frame, and presents it on an AXI-Stream master tagged with the requester index.
- Sits between the per-channel acquisition logic (requesters) and the ADC pins; replaces free-running sample timing with request-driven scheduling.

Parameters:
- NUM_REQ, 4, number of requesters (2..4); index width is 2 bits.
- SCLK_DIV, 10, clk cycles per SCLK half-period (>=1).
- CS_HIGH_CYC, 600, clk cycles CS is held high for conversion before each frame (>=1).
- NBITS, 16, bits per frame; fixed at 16.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  level request per requester; a request is held high until its grant is seen
- grant  out  NUM_REQ  one-hot; marks the requester whose sample is in flight
- chan_sel  out  2  analog mux select; equals the granted index
- cs_n  out  1  ADC chip select, active low
- sclk  out  1  ADC serial clock
- miso  in  1  ADC serial data
- m_axis_tdata  out  16  sample, MSB = first bit received
- m_axis_tuser  out  2  requester index of the sample
- m_axis_tvalid  out  1  AXIS valid
- m_axis_tready  in  1  AXIS ready
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - grant=0, chan_sel=0, cs_n=1, sclk=0, tdata=0, tuser=0, tvalid=0, busy=0.
  - FSM=IDLE; round-robin pointer gives index 0 highest priority.
- Reset mid-operation: at the next edge all outputs take their reset values, any in-flight frame is discarded, and the pointer resets. No partial word is ever emitted.
- FSM states: IDLE, CONV, SHIFT, HOLD.
- IDLE:
  - If any req bit is high, register a grant for the first set bit starting at (last_granted+1) mod NUM_REQ; priority after reset starts at 0.
  - On that edge (call it cycle G): grant and chan_sel update, and FSM goes to CONV.
  - Requests with no grant are ignored; a single req bit is granted repeatedly.
- CONV:
  - cs_n=1, sclk=0 for exactly CS_HIGH_CYC cycles.
  - cs_n falls at edge G+CS_HIGH_CYC, and FSM goes to SHIFT.
- SHIFT (cs_n falls at edge F):
  - sclk is low for SCLK_DIV cycles, then high for SCLK_DIV cycles, repeated 16 times.
  - Rising sclk edges are at F+SCLK_DIV+2k·SCLK_DIV, for k=0..15.
  - At each edge that drives sclk 0→1, the current miso value is shifted into the LSB of a 16-bit shift register (MSB first).
  - At edge F+32·SCLK_DIV: sclk=0, cs_n=1, and the frame is complete.
- Frame complete:
  - If the output register is empty, or tvalid&&tready in that same cycle, then on that edge: tdata=shift value, tuser=granted index, tvalid=1, grant=0, and FSM goes to IDLE.
  - Otherwise FSM goes to HOLD.
- HOLD:
  - cs_n=1, sclk=0, grant stays asserted, and the completed word is kept.
  - Loads the output on the first cycle the register is empty or being accepted, then goes to IDLE.
  - Samples are never dropped or overwritten.
- AXIS:
  - tvalid/tdata/tuser stay stable while tvalid&&!tready.
  - tvalid clears on an accepting edge unless a new word loads on the same edge, in which case tvalid stays 1 with the new data.
- A req drop mid-frame does not abort the frame.
- Throughput with tready=1: one sample per CS_HIGH_CYC+32·SCLK_DIV+1 cycles (the extra cycle is IDLE arbitration).
- busy=1 in CONV, SHIFT and HOLD.
- Counters are sized from the parameters and never wrap within a frame.

Test Plan:
- Only req[2]=1, SCLK_DIV=2, CS_HIGH_CYC=5, miso drives 0xA5C3 MSB-first, changing after each sclk fall:
  - grant=0100 at G, cs_n falls at G+5, 16 sclk rising edges 4 cycles apart, cs_n rises at G+69.
  - Same edge: tvalid=1, tdata=0xA5C3, tuser=2.
- req=1111 held, tready=1:
  - grants issue in order 0,1,2,3,0; tuser follows the same order.
  - Exactly one grant bit is high at a time.
- tready=0 with two requesters:
  - first word held stable (tdata/tuser unchanged).
  - second frame completes into HOLD with cs_n=1 and grant held.
  - On tready=1 for one cycle: first word accepted and second word loaded on the same edge, tvalid stays 1; no loss.
- reset pulsed during SHIFT (after 7 sclk rises):
  - next edge: cs_n=1, sclk=0, grant=0, tvalid=0.
  - After reset, req[1]|req[0] grants index 0 first.
- miso held constantly 1, then constantly 0 → tdata 0xFFFF, then 0x0000, confirming no stale shift bits.
- SCLK_DIV=1, CS_HIGH_CYC=1 → sclk toggles every cycle, frame is 32 cycles long, and the sample is correct.
